// File: rtl/mem_responder_if.sv
// Request/response bundle between the processor memory stage and mem_responder.
// The processor drives the master side; the responder implements the slave side.
interface mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );
endinterface

// File: rtl/mem_responder.sv
// Word-organised data memory with programmable wait states and a one-cycle response.
// Define MEM_RSP_ERR_EN to flag (and suppress) accesses above the memory depth.
//
// state | meaning
// IDLE  | ready for a request
// WAIT  | counting down the wait states of the accepted request
// RESP  | one-cycle response strobe
module mem_responder #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 2
) (
  input  logic            CLK,
  input  logic            Reset,
  mem_responder_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [3:0]          be_q, be_d;
  logic                oor_q, oor_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;

  logic [DATA_W-1:0]   mem_q [2**ADDR_W];

  logic                accept;
  logic                req_oor;
  logic                commit;
  logic                c_we;
  logic                c_oor;
  logic [ADDR_W-1:0]   c_addr;
  logic [DATA_W-1:0]   c_wdata;
  logic [3:0]          c_be;
  logic                wr_en;
  logic [DATA_W-1:0]   wr_word;
  logic                unused_addr_bits;

  assign unused_addr_bits = ^{bus.req_addr[31:ADDR_W+2], bus.req_addr[1:0]};

`ifdef MEM_RSP_ERR_EN
  assign req_oor = (bus.req_addr >> (ADDR_W + 2)) != 32'd0;
`else
  assign req_oor = 1'b0;
`endif

  assign bus.req_ready = Reset && (state_q == S_IDLE);
  assign accept        = bus.req_valid && bus.req_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    oor_d   = oor_q;
    commit  = 1'b0;

    // With zero wait states the commit happens on the accept edge itself,
    // so the commit path must see the live request, not the latched copy.
    if (state_q == S_IDLE) begin
      c_we    = bus.req_we;
      c_oor   = req_oor;
      c_addr  = bus.req_addr[ADDR_W+1:2];
      c_wdata = bus.req_wdata;
      c_be    = bus.req_be;
    end else begin
      c_we    = we_q;
      c_oor   = oor_q;
      c_addr  = addr_q;
      c_wdata = wdata_q;
      c_be    = be_q;
    end

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          we_d    = bus.req_we;
          addr_d  = bus.req_addr[ADDR_W+1:2];
          wdata_d = bus.req_wdata;
          be_d    = bus.req_be;
          oor_d   = req_oor;
          cnt_d   = 4'(LATENCY);
          if (LATENCY == 0) begin
            state_d = S_RESP;
            commit  = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_RESP;
          commit  = 1'b1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    rdata_d = '0;
    err_d   = 1'b0;
    if (commit) begin
      err_d = c_oor;
      if (!c_we && !c_oor) rdata_d = mem_q[c_addr];
    end

    wr_en   = commit && c_we && !c_oor && Reset;
    wr_word = mem_q[c_addr];
    for (int b = 0; b < 4; b++) begin
      if (c_be[b]) wr_word[8*b +: 8] = c_wdata[8*b +: 8];
    end
  end

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      oor_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      oor_q   <= oor_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Memory contents deliberately survive reset.
  always_ff @(posedge CLK) begin
    if (wr_en) mem_q[c_addr] <= wr_word;
  end

  assign bus.rsp_valid = (state_q == S_RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign bus.busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Random and directed bench for mem_responder: one instance with 2 wait states, one with none,
// both checked every cycle against a transaction-level model keyed on absolute edge numbers.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tv   [2];
  logic        twe  [2];
  logic [31:0] taddr[2];
  logic [31:0] twd  [2];
  logic [3:0]  tbe  [2];
  logic        trdy [2];
  logic        tval [2];
  logic [31:0] trd  [2];
  logic        terr [2];
  logic        tbusy[2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_responder_if bus();
    assign bus.req_valid = tv[g];
    assign bus.req_we    = twe[g];
    assign bus.req_addr  = taddr[g];
    assign bus.req_wdata = twd[g];
    assign bus.req_be    = tbe[g];
    assign trdy[g]  = bus.req_ready;
    assign tval[g]  = bus.rsp_valid;
    assign trd[g]   = bus.rsp_rdata;
    assign terr[g]  = bus.rsp_err;
    assign tbusy[g] = bus.busy;
    mem_responder #(.ADDR_W(10), .DATA_W(32), .LATENCY(g == 0 ? 2 : 0)) u_dut (
      .CLK   (clk),
      .Reset (rst_n),
      .bus   (bus.slave)
    );
  end

  int n_total = 0;
  int n_pass  = 0;
  bit chk_en  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  task automatic timeout_fail(input string nm);
    n_total++;
    $display("FAIL %s: timed out waiting for DUT at %0t", nm, $time);
  endtask

  // ---------------- behavioural model ----------------
  int          lat[2] = '{2, 0};
  logic [31:0] mmem[2][1024];
  bit          pend[2];
  longint      commit_at[2];
  bit          m_we[2];
  logic [31:0] m_addr[2], m_wd[2];
  logic [3:0]  m_be[2];
  bit          e_val[2];
  logic [31:0] e_rd[2];
  bit          e_err[2];
  longint      edge_no = 0;

  function automatic bit out_of_range(input logic [31:0] a);
`ifdef MEM_RSP_ERR_EN
    return a[31:12] != 20'd0;
`else
    return (a[31:12] != 20'd0) && 1'b0;
`endif
  endfunction

  always @(posedge clk) begin
    bit idle_b;
    bit oor;
    int w;
    edge_no++;
    for (int i = 0; i < 2; i++) begin
      e_val[i] = 0;
      e_rd[i]  = '0;
      e_err[i] = 0;
      if (!rst_n) begin
        pend[i] = 0;
      end else begin
        idle_b = !pend[i];
        if (pend[i] && edge_no == commit_at[i] + 1) pend[i] = 0;
        if (idle_b && tv[i]) begin
          pend[i]      = 1;
          commit_at[i] = edge_no + lat[i];
          m_we[i]   = twe[i];
          m_addr[i] = taddr[i];
          m_wd[i]   = twd[i];
          m_be[i]   = tbe[i];
        end
        if (pend[i] && edge_no == commit_at[i]) begin
          oor = out_of_range(m_addr[i]);
          w   = int'(m_addr[i][11:2]);
          e_val[i] = 1;
          e_err[i] = oor;
          if (m_we[i]) begin
            if (!oor)
              for (int b = 0; b < 4; b++)
                if (m_be[i][b]) mmem[i][w][8*b +: 8] = m_wd[i][8*b +: 8];
          end else begin
            e_rd[i] = oor ? 32'd0 : mmem[i][w];
          end
        end
      end
    end
  end

  always @(posedge clk) begin
    #4;
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("ready[%0d]", i), {31'd0, trdy[i]}, {31'd0, !pend[i] && rst_n});
        chk($sformatf("busy[%0d]", i), {31'd0, tbusy[i]}, {31'd0, pend[i]});
        chk($sformatf("rsp_valid[%0d]", i), {31'd0, tval[i]}, {31'd0, e_val[i]});
        if (e_val[i]) begin
          chk($sformatf("rsp_rdata[%0d]", i), trd[i], e_rd[i]);
          chk($sformatf("rsp_err[%0d]", i), {31'd0, terr[i]}, {31'd0, e_err[i]});
        end
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic accept_req(input int i, input bit we, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [3:0] be, output bit ok);
    ok = 0;
    @(negedge clk);
    tv[i] = 1; twe[i] = we; taddr[i] = addr; twd[i] = wd; tbe[i] = be;
    for (int k = 0; k < 50; k++) begin
      #1;
      if (trdy[i]) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) timeout_fail("accept");
    @(posedge clk); #4;
    tv[i] = 0;
  endtask

  task automatic wait_rsp(input int i, output logic [31:0] rd, output bit err, output int n);
    n = 1; rd = '0; err = 0;
    for (int k = 0; k < 40; k++) begin
      if (tval[i]) begin rd = trd[i]; err = terr[i]; return; end
      @(posedge clk); #4;
      n++;
    end
    timeout_fail("response");
  endtask

  task automatic do_txn(input int i, input bit we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] be, output logic [31:0] rd, output bit err, output int n);
    bit ok;
    accept_req(i, we, addr, wd, be, ok);
    wait_rsp(i, rd, err, n);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] rd;
    bit          err, ok;
    int          n;
    logic [31:0] hi;

    rst_n = 0;
    for (int i = 0; i < 2; i++) begin
      tv[i] = 1; twe[i] = 1; taddr[i] = 32'h10; twd[i] = 32'h5555_AAAA; tbe[i] = 4'hF;
    end
    repeat (3) begin
      @(posedge clk); #4;
      for (int i = 0; i < 2; i++) begin
        chk("rst_ready", {31'd0, trdy[i]}, 32'd0);
        chk("rst_valid", {31'd0, tval[i]}, 32'd0);
        chk("rst_rdata", trd[i], 32'd0);
        chk("rst_busy", {31'd0, tbusy[i]}, 32'd0);
      end
    end
    @(negedge clk);
    rst_n = 1;
    tv[0] = 0; tv[1] = 0;
    #1;
    chk("post_rst_ready0", {31'd0, trdy[0]}, 32'd1);
    chk("post_rst_ready1", {31'd0, trdy[1]}, 32'd1);
    chk_en = 1;

    for (int i = 0; i < 2; i++)
      for (int w = 0; w < 16; w++)
        do_txn(i, 1, 32'(w * 4), 32'd0, 4'hF, rd, err, n);

    // stores and byte-masked merge on the 2-wait-state instance
    do_txn(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, rd, err, n);
    chk("t2_store_lat", 32'(n), 32'd3);
    chk("t2_store_rdata", rd, 32'd0);
    do_txn(0, 0, 32'h10, 32'd0, 4'h0, rd, err, n);
    chk("t2_load_lat", 32'(n), 32'd3);
    chk("t2_load_rdata", rd, 32'hDEADBEEF);
    do_txn(0, 1, 32'h10, 32'h11223344, 4'b0101, rd, err, n);
    do_txn(0, 0, 32'h10, 32'd0, 4'hF, rd, err, n);
    chk("t3_merge", rd, 32'hDE22BE44);
    do_txn(0, 1, 32'h10, 32'hFFFF_FFFF, 4'h0, rd, err, n);
    chk("be0_store_rsp", 32'(n), 32'd3);
    do_txn(0, 0, 32'h12, 32'd0, 4'h0, rd, err, n);
    chk("be0_unchanged", rd, 32'hDE22BE44);

    // zero wait states: back-to-back requests
    @(negedge clk);
    tv[1] = 1; twe[1] = 0; taddr[1] = 32'h10; twd[1] = 32'd0; tbe[1] = 4'hF;
    #1;
    chk("t4_ready_T", {31'd0, trdy[1]}, 32'd1);
    @(posedge clk); #4;
    chk("t4_valid_T1", {31'd0, tval[1]}, 32'd1);
    chk("t4_ready_T1", {31'd0, trdy[1]}, 32'd0);
    @(posedge clk); #4;
    chk("t4_ready_T2", {31'd0, trdy[1]}, 32'd1);
    chk("t4_valid_T2", {31'd0, tval[1]}, 32'd0);
    @(posedge clk); #4;
    chk("t4_valid_T3", {31'd0, tval[1]}, 32'd1);
    tv[1] = 0;

    // reset during WAIT drops the store
    accept_req(0, 1, 32'h20, 32'hCAFEF00D, 4'hF, ok);
    @(negedge clk);
    rst_n = 0;
    repeat (2) begin
      @(posedge clk); #4;
      chk("t5_no_rsp", {31'd0, tval[0]}, 32'd0);
    end
    @(negedge clk);
    rst_n = 1;
    do_txn(0, 0, 32'h20, 32'd0, 4'hF, rd, err, n);
    chk("t5_load_after_rst", rd, 32'd0);

    // address above the memory depth
    do_txn(0, 1, 32'h1000, 32'h12345678, 4'hF, rd, err, n);
`ifdef MEM_RSP_ERR_EN
    chk("t6_store_err", {31'd0, err}, 32'd1);
    do_txn(0, 0, 32'h0, 32'd0, 4'hF, rd, err, n);
    chk("t6_word0", rd, 32'd0);
    chk("t6_load_err", {31'd0, err}, 32'd0);
`else
    chk("t6_store_err", {31'd0, err}, 32'd0);
    do_txn(0, 0, 32'h0, 32'd0, 4'hF, rd, err, n);
    chk("t6_word0", rd, 32'h12345678);
    chk("t6_load_err", {31'd0, err}, 32'd0);
`endif

    // random traffic with occasional resets
    repeat (3000) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        tv[i]  = ($urandom_range(0, 9) < 6);
        twe[i] = $urandom_range(0, 1) == 1;
        hi     = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 32'hFFFFF)) : 32'd0;
        taddr[i] = {hi[19:0], 6'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
        twd[i] = $urandom;
        tbe[i] = 4'($urandom_range(0, 15));
      end
      rst_n = ($urandom_range(0, 299) != 0);
    end
    @(negedge clk);
    tv[0] = 0; tv[1] = 0; rst_n = 1;
    repeat (6) @(posedge clk);
    #4;
    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
